// File: rtl/vx_tb_mem_line_loader_pkg.sv
// Shared types and constants for the program-image line loader.
package vx_tb_mem_line_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } mem_loader_state_t;

    localparam int L1_LINE_SIZE          = 64;
    localparam int MEM_ADDR_WIDTH        = 32;
    localparam int L1_MEM_ARB_TAG_WIDTH  = 8;

    localparam int LOADER_WORD_WIDTH     = 32;
    localparam int LOADER_LINE_WORDS     = L1_LINE_SIZE / 4;
    localparam int LOADER_ADDR_WIDTH     = MEM_ADDR_WIDTH - $clog2(L1_LINE_SIZE);
    localparam int LOADER_TAG_WIDTH      = L1_MEM_ARB_TAG_WIDTH;

    localparam logic [31:0] LOADER_FILL_PATTERN = 32'hdeadbeef;

    // Byte addresses of the code and data segments of the program image.
    localparam logic [31:0] USER_BASE_ADDR    = 32'h0001_0000;
    localparam logic [31:0] CODE_CS_BASE_ADDR = USER_BASE_ADDR;
    localparam logic [31:0] DATA_CS_BASE_ADDR = USER_BASE_ADDR + 32'h0000_0400;

    // Convert a byte address to a cache-line address.
    function automatic logic [31:0] byte_to_line(input logic [31:0] byte_addr);
        return byte_addr >> $clog2(L1_LINE_SIZE);
    endfunction

    localparam logic [31:0] MEM_LOAD_BOOT_ADDR      = byte_to_line(CODE_CS_BASE_ADDR);
    localparam logic [31:0] MEM_LOAD_DATA_BASE_ADDR = byte_to_line(DATA_CS_BASE_ADDR);

endpackage

// File: rtl/vx_tb_line_packer.sv
// Collects stream words into one cache line with per-word byte enables.
module vx_tb_line_packer
    import vx_tb_mem_line_loader_pkg::*;
#(
    parameter int WORD_WIDTH = LOADER_WORD_WIDTH,
    parameter int LINE_WORDS = LOADER_LINE_WORDS,
    localparam int CNT_WIDTH  = $clog2(LINE_WORDS + 1),
    localparam int WORD_BYTES = WORD_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             wr_en,
    input  logic [WORD_WIDTH-1:0]            wr_data,
    output logic [CNT_WIDTH-1:0]             count,
    output logic [WORD_WIDTH*LINE_WORDS-1:0] line_data,
    output logic [WORD_BYTES*LINE_WORDS-1:0] line_byteen
);

    localparam logic [WORD_WIDTH-1:0] FILL_WORD = WORD_WIDTH'(LOADER_FILL_PATTERN);

    logic [CNT_WIDTH-1:0]             count_q, count_d;
    logic [WORD_WIDTH*LINE_WORDS-1:0] data_q, data_d;
    logic [WORD_BYTES*LINE_WORDS-1:0] byteen_q, byteen_d;
    logic [LINE_WORDS-1:0]            slot_hit;

    // One-hot slot select: the word goes to the slot indexed by the fill count.
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_slot
        assign slot_hit[gi] = wr_en && (count_q == CNT_WIDTH'(gi));
    end

    // Next line contents: clear back to the fill pattern, or drop the word in its slot.
    always_comb begin
        data_d   = data_q;
        byteen_d = byteen_q;
        count_d  = count_q;
        if (clear) begin
            data_d   = {LINE_WORDS{FILL_WORD}};
            byteen_d = '0;
            count_d  = '0;
        end else if (wr_en) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                if (slot_hit[i]) begin
                    data_d[i*WORD_WIDTH +: WORD_WIDTH]   = wr_data;
                    byteen_d[i*WORD_BYTES +: WORD_BYTES] = '1;
                end
            end
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    // Line registers; reset leaves an all-zero line until the first load starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            byteen_q <= '0;
            count_q  <= '0;
        end else begin
            data_q   <= data_d;
            byteen_q <= byteen_d;
            count_q  <= count_d;
        end
    end

    assign count       = count_q;
    assign line_data   = data_q;
    assign line_byteen = byteen_q;

endmodule

// File: rtl/vx_tb_mem_line_loader.sv
// Turns a code/data word stream into handshaked cache-line write requests.
module vx_tb_mem_line_loader
    import vx_tb_mem_line_loader_pkg::*;
#(
    parameter int WORD_WIDTH = LOADER_WORD_WIDTH,
    parameter int LINE_WORDS = LOADER_LINE_WORDS,
    parameter int ADDR_WIDTH = LOADER_ADDR_WIDTH,
    parameter int TAG_WIDTH  = LOADER_TAG_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] CODE_BASE_ADDR = ADDR_WIDTH'(MEM_LOAD_BOOT_ADDR),
    parameter logic [ADDR_WIDTH-1:0] DATA_BASE_ADDR = ADDR_WIDTH'(MEM_LOAD_DATA_BASE_ADDR),
    localparam int LINE_BITS  = WORD_WIDTH * LINE_WORDS,
    localparam int LINE_BYTES = LINE_BITS / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  word_valid,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_seg,
    input  logic                  word_last,
    output logic                  word_ready,
    output logic                  mem_req_valid,
    output logic                  mem_req_rw,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [LINE_BITS-1:0]  mem_req_data,
    output logic [LINE_BYTES-1:0] mem_req_byteen,
    output logic [TAG_WIDTH-1:0]  mem_req_tag,
    input  logic                  mem_req_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int CNT_WIDTH = $clog2(LINE_WORDS + 1);

    mem_loader_state_t     state_q, state_d;
    logic [ADDR_WIDTH-1:0] code_addr_q, code_addr_d;
    logic [ADDR_WIDTH-1:0] data_addr_q, data_addr_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic                  cur_seg_q, cur_seg_d;
    logic                  last_line_q, last_line_d;
    logic                  overflow_q, overflow_d;
    logic                  req_valid_q, req_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [CNT_WIDTH-1:0]  fill_count;
    logic                  seg_switch;
    logic                  word_accept;
    logic                  start_ok;
    logic                  handshake;

    // A word from the other segment while a line is partly filled forces a flush.
    assign seg_switch  = word_valid && (fill_count != '0) && (word_seg != cur_seg_q);
    assign word_ready  = (state_q == FILL) && !seg_switch;
    assign word_accept = word_valid && word_ready;
    assign start_ok    = start && ((state_q == IDLE) || (state_q == DONE));
    assign handshake   = (state_q == ISSUE) && mem_req_ready;

    vx_tb_line_packer #(
        .WORD_WIDTH (WORD_WIDTH),
        .LINE_WORDS (LINE_WORDS)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear       (start_ok || handshake),
        .wr_en       (word_accept),
        .wr_data     (word_data),
        .count       (fill_count),
        .line_data   (mem_req_data),
        .line_byteen (mem_req_byteen)
    );

    // Next-state logic for the load sequencer, address counters and status flags.
    always_comb begin
        state_d     = state_q;
        code_addr_d = code_addr_q;
        data_addr_d = data_addr_q;
        tag_d       = tag_q;
        cur_seg_d   = cur_seg_q;
        last_line_d = last_line_q;
        overflow_d  = overflow_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = FILL;
                    code_addr_d = CODE_BASE_ADDR;
                    data_addr_d = DATA_BASE_ADDR;
                    tag_d       = '0;
                    cur_seg_d   = 1'b0;
                    last_line_d = 1'b0;
                    overflow_d  = 1'b0;
                end
            end
            FILL: begin
                if (seg_switch) begin
                    state_d = ISSUE;
                end else if (word_accept) begin
                    if (fill_count == '0) begin
                        cur_seg_d = word_seg;
                    end
                    if ((fill_count == CNT_WIDTH'(LINE_WORDS - 1)) || word_last) begin
                        state_d     = ISSUE;
                        last_line_d = word_last;
                    end
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    if (cur_seg_q) begin
                        data_addr_d = data_addr_q + ADDR_WIDTH'(1);
                    end else begin
                        code_addr_d = code_addr_q + ADDR_WIDTH'(1);
                        // Code has run into the data segment; the write still goes out.
                        if (code_addr_q >= DATA_BASE_ADDR) begin
                            overflow_d = 1'b1;
                        end
                    end
                    tag_d   = tag_q + TAG_WIDTH'(1);
                    state_d = last_line_q ? DONE : FILL;
                end
            end
            default: state_d = IDLE;
        endcase
        req_valid_d = (state_d == ISSUE);
        busy_d      = (state_d == FILL) || (state_d == ISSUE);
        done_d      = (state_d == DONE);
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            code_addr_q <= '0;
            data_addr_q <= '0;
            tag_q       <= '0;
            cur_seg_q   <= 1'b0;
            last_line_q <= 1'b0;
            overflow_q  <= 1'b0;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_addr_q <= code_addr_d;
            data_addr_q <= data_addr_d;
            tag_q       <= tag_d;
            cur_seg_q   <= cur_seg_d;
            last_line_q <= last_line_d;
            overflow_q  <= overflow_d;
            req_valid_q <= req_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_req_valid = req_valid_q;
    assign mem_req_rw    = 1'b1;
    assign mem_req_addr  = cur_seg_q ? data_addr_q : code_addr_q;
    assign mem_req_tag   = tag_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_vx_tb_mem_line_loader.sv
// Directed bench for the program-image line loader.
module tb_vx_tb_mem_line_loader;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         word_valid = 1'b0;
    logic [31:0]  word_data = '0;
    logic         word_seg = 1'b0;
    logic         word_last = 1'b0;
    logic         word_ready;
    logic         mem_req_valid;
    logic         mem_req_rw;
    logic [25:0]  mem_req_addr;
    logic [511:0] mem_req_data;
    logic [63:0]  mem_req_byteen;
    logic [7:0]   mem_req_tag;
    logic         mem_req_ready = 1'b0;
    logic         busy;
    logic         done;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int start_cyc = 0;

    typedef struct packed {
        logic [25:0]  addr;
        logic [511:0] data;
        logic [63:0]  be;
        logic [7:0]   tag;
    } rec_t;
    rec_t wq[$];

    vx_tb_mem_line_loader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .word_valid     (word_valid),
        .word_data      (word_data),
        .word_seg       (word_seg),
        .word_last      (word_last),
        .word_ready     (word_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_byteen (mem_req_byteen),
        .mem_req_tag    (mem_req_tag),
        .mem_req_ready  (mem_req_ready),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Memory-side capture: a request seen valid&&ready here completes on the next edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!reset && mem_req_valid && mem_req_ready)
                wq.push_back('{mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag});
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        step();
        start = 1'b1;
        start_cyc = cyc_cnt + 1;
        step();
        start = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d, input logic seg, input logic last);
        int w;
        word_valid = 1'b1;
        word_data  = d;
        word_seg   = seg;
        word_last  = last;
        #1;
        w = 0;
        while (!word_ready && w < 64) begin
            step();
            w++;
        end
        if (w >= 64) chk("word_ready_timeout", word_ready, 1);
        step();
        word_valid = 1'b0;
        word_last  = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (!done && n < bound) begin
            step();
            n++;
        end
        chk("done_timeout", done, 1);
    endtask

    function automatic logic [511:0] mkline(input logic [31:0] base, input int n);
        logic [511:0] l;
        for (int i = 0; i < 16; i++)
            l[i*32 +: 32] = (i < n) ? base + 32'(i) : 32'hdeadbeef;
        return l;
    endfunction

    function automatic logic [63:0] mkbe(input int n);
        logic [63:0] b;
        b = '0;
        for (int i = 0; i < n; i++) b[i*4 +: 4] = 4'hf;
        return b;
    endfunction

    function automatic rec_t get_rec(input int idx);
        if (idx < wq.size()) return wq[idx];
        return '0;
    endfunction

    initial begin
        rec_t r;
        logic [511:0] exp_line;

        // Reset state
        step();
        step();
        chk("rst_word_ready", word_ready, 0);
        chk("rst_valid", mem_req_valid, 0);
        chk("rst_rw", mem_req_rw, 1);
        chk("rst_addr", mem_req_addr, 0);
        chk("rst_data", mem_req_data, 0);
        chk("rst_byteen", mem_req_byteen, 0);
        chk("rst_tag", mem_req_tag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;
        step();
        chk("idle_busy", busy, 0);
        $display("reset: checks=%0d errors=%0d", checks, errors);

        // Two full code lines at full rate
        mem_req_ready = 1'b1;
        pulse_start();
        chk("t1_busy", busy, 1);
        chk("t1_word_ready", word_ready, 1);
        for (int i = 0; i < 32; i++) push_word(32'h1000_0000 + 32'(i), 1'b0, i == 31);
        wait_done(100);
        chk("t1_done_cycle", cyc_cnt - start_cyc + 1, 35);
        chk("t1_done_word_ready", word_ready, 0);
        chk("t1_nwrites", wq.size(), 2);
        r = get_rec(0);
        chk("t1_r0_addr", r.addr, 26'h400);
        chk("t1_r0_tag", r.tag, 0);
        chk("t1_r0_be", r.be, 64'hffff_ffff_ffff_ffff);
        chk("t1_r0_data", r.data, mkline(32'h1000_0000, 16));
        r = get_rec(1);
        chk("t1_r1_addr", r.addr, 26'h401);
        chk("t1_r1_tag", r.tag, 1);
        chk("t1_r1_data", r.data, mkline(32'h1000_0010, 16));
        $display("full-rate code load: checks=%0d errors=%0d", checks, errors);

        // Restart from DONE, code then data, with an ignored start in FILL
        wq.delete();
        pulse_start();
        chk("t2_done_drop", done, 0);
        chk("t2_busy", busy, 1);
        push_word(32'hc0de_0000, 1'b0, 1'b0);
        push_word(32'hc0de_0001, 1'b0, 1'b0);
        pulse_start();
        chk("t2_fill_start_busy", busy, 1);
        push_word(32'hc0de_0002, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) push_word(32'hda7a_0000 + 32'(i), 1'b1, i == 16);
        wait_done(100);
        chk("t2_nwrites", wq.size(), 3);
        r = get_rec(0);
        chk("t2_r0_addr", r.addr, 26'h400);
        chk("t2_r0_tag", r.tag, 0);
        chk("t2_r0_be", r.be, 64'h0000_0000_0000_0fff);
        chk("t2_r0_data", r.data, mkline(32'hc0de_0000, 3));
        r = get_rec(1);
        chk("t2_r1_addr", r.addr, 26'h410);
        chk("t2_r1_be", r.be, mkbe(16));
        chk("t2_r1_data", r.data, mkline(32'hda7a_0000, 16));
        r = get_rec(2);
        chk("t2_r2_addr", r.addr, 26'h411);
        chk("t2_r2_tag", r.tag, 2);
        chk("t2_r2_be", r.be, 64'h0000_0000_0000_000f);
        chk("t2_r2_data", r.data, mkline(32'hda7a_0010, 1));
        $display("segment switch: checks=%0d errors=%0d", checks, errors);

        // Memory back-pressure during ISSUE
        wq.delete();
        mem_req_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 16; i++) push_word(32'h3000_0000 + 32'(i), 1'b0, 1'b0);
        word_valid = 1'b1;
        word_data  = 32'h3000_0010;
        word_seg   = 1'b0;
        #1;
        exp_line = mkline(32'h3000_0000, 16);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_valid_%0d", k), mem_req_valid, 1);
            chk($sformatf("t3_addr_%0d", k), mem_req_addr, 26'h400);
            chk($sformatf("t3_tag_%0d", k), mem_req_tag, 0);
            chk($sformatf("t3_data_%0d", k), mem_req_data, exp_line);
            chk($sformatf("t3_word_ready_%0d", k), word_ready, 0);
            step();
        end
        mem_req_ready = 1'b1;
        for (int i = 16; i < 32; i++) push_word(32'h3000_0000 + 32'(i), 1'b0, i == 31);
        wait_done(100);
        chk("t3_nwrites", wq.size(), 2);
        r = get_rec(0);
        chk("t3_r0_data", r.data, exp_line);
        r = get_rec(1);
        chk("t3_r1_addr", r.addr, 26'h401);
        chk("t3_r1_data", r.data, mkline(32'h3000_0010, 16));
        $display("back-pressure: checks=%0d errors=%0d", checks, errors);

        // Seventeen code lines run into the data segment
        wq.delete();
        pulse_start();
        for (int i = 0; i < 272; i++) push_word(32'h4000_0000 + 32'(i), 1'b0, i == 271);
        chk("t4_last_issue_valid", mem_req_valid, 1);
        chk("t4_last_issue_addr", mem_req_addr, 26'h410);
        chk("t4_overflow_before", overflow, 0);
        step();
        chk("t4_overflow_after", overflow, 1);
        chk("t4_done", done, 1);
        chk("t4_nwrites", wq.size(), 17);
        r = get_rec(15);
        chk("t4_r15_addr", r.addr, 26'h40f);
        r = get_rec(16);
        chk("t4_r16_addr", r.addr, 26'h410);
        chk("t4_r16_tag", r.tag, 16);
        chk("t4_r16_data", r.data, mkline(32'h4000_0100, 16));
        $display("overflow: checks=%0d errors=%0d", checks, errors);

        // Reset during ISSUE, then a fresh load
        mem_req_ready = 1'b0;
        pulse_start();
        chk("t5_overflow_cleared", overflow, 0);
        for (int i = 0; i < 16; i++) push_word(32'h5000_0000 + 32'(i), 1'b0, 1'b0);
        chk("t5_issue_valid", mem_req_valid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_rst_valid", mem_req_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_tag", mem_req_tag, 0);
        wq.delete();
        mem_req_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 16; i++) push_word(32'h5100_0000 + 32'(i), 1'b0, i == 15);
        wait_done(100);
        chk("t5_nwrites", wq.size(), 1);
        r = get_rec(0);
        chk("t5_r0_addr", r.addr, 26'h400);
        chk("t5_r0_tag", r.tag, 0);
        chk("t5_r0_data", r.data, mkline(32'h5100_0000, 16));
        $display("reset in ISSUE: checks=%0d errors=%0d", checks, errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
